bram_stream_loader: RTL and testbench

BRAM_STREAM_LOADER -- requirements
Module: bram_stream_loader

---
 rtl/bram_pkg.sv | 20 ++
 rtl/bram_rd_fifo.sv | 57 +++++
 rtl/bram_stream_loader.sv | 165 ++++++++++++++++
 tb/tb_bram_stream_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and defaults for the BRAM stream loader: FSM state encoding,
// default geometry and the output-FIFO sizing rule.
package bram_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    // The FIFO must absorb every read in flight plus one beat held under a stall.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO with valid/ready on both sides. It buffers BRAM read
// data so the downstream stream can stall without losing beats.
module bram_rd_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) wr_idx <= bump(wr_idx);
            if (pop)  rd_idx <= bump(rd_idx);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // validity, and leaving data flops reset-free keeps them mappable to RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= in_data;
    end

endmodule

// File: rtl/bram_stream_loader.sv
// Captures one upstream frame into an external BRAM (port A) and replays it on
// request as a downstream stream, with credit-based flow control on reads.
module bram_stream_loader
    import bram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              rd_start,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              bram_en,
    output logic              bram_we,
    output logic              busy,
    output logic [ADDR_W:0]   frame_len,
    output logic              ovf
);

    localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W      = CNT_W + 1;
    localparam logic [ADDR_W-1:0] WR_MAX   = '1;
    localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [CNT_W-1:0]  inflight;
    logic [RD_LAT:0]   pipe_vld;
    logic [RD_LAT:0]   pipe_last;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_in_ready;
    logic [DATA_W:0]   fifo_out;

    logic              s_hs;
    logic              m_hs;
    logic              rd_go;
    logic              issue_rd;
    logic              issue_last;
    logic              cap_push;
    logic [CRD_W-1:0]  credit_used;

    assign s_ready = rst_n && (state != ST_READ);
    assign busy    = (state != ST_IDLE);
    assign m_data  = fifo_out[DATA_W-1:0];
    assign m_last  = fifo_out[DATA_W];

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    always_comb begin
        s_hs        = s_valid & s_ready;
        m_hs        = m_valid & m_ready;
        rd_go       = (state == ST_IDLE) && rd_start && (frame_len != '0);
        cap_push    = pipe_vld[RD_LAT] & fifo_in_ready;
        credit_used = CRD_W'(fifo_count) + CRD_W'(inflight) - CRD_W'(m_hs);
        issue_last  = (rd_ptr == frame_len - 1'b1);
        issue_rd    = 1'b0;
        // A beat accepted alongside rd_start owns the port next cycle, so the
        // first read is then issued one cycle later from READ.
        if (rd_go && !s_hs) begin
            issue_rd = 1'b1;
        end else if (state == ST_READ && rd_ptr < frame_len &&
                     credit_used < CRD_W'(FIFO_DEPTH)) begin
            issue_rd = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_len <= '0;
            ovf       <= 1'b0;
            inflight  <= '0;
            pipe_vld  <= '0;
            pipe_last <= '0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            pipe_vld  <= {pipe_vld[RD_LAT-1:0], issue_rd};
            pipe_last <= {pipe_last[RD_LAT-1:0], issue_rd & issue_last};
            inflight  <= inflight + CNT_W'(issue_rd) - CNT_W'(cap_push);

            if (s_hs) begin
                bram_en   <= 1'b1;
                bram_we   <= 1'b1;
                bram_din  <= s_data;
                bram_addr <= (state == ST_IDLE) ? '0 : wr_ptr;
            end else if (issue_rd) begin
                bram_en   <= 1'b1;
                bram_addr <= rd_ptr[ADDR_W-1:0];
                rd_ptr    <= rd_ptr + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (s_hs) begin
                        wr_ptr <= ADDR_W'(1);
                        if (s_last) frame_len <= (ADDR_W+1)'(1);
                    end
                    if (rd_go) begin
                        state <= ST_READ;
                    end else if (s_hs && !s_last) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (s_hs) begin
                        if (s_last) begin
                            frame_len <= {1'b0, wr_ptr} + 1'b1;
                            state     <= ST_IDLE;
                        end else if (wr_ptr == WR_MAX) begin
                            frame_len <= FULL_LEN;
                            ovf       <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (m_hs && m_last) begin
                        state  <= ST_IDLE;
                        rd_ptr <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (pipe_vld[RD_LAT]),
        .in_ready  (fifo_in_ready),
        .in_data   ({pipe_last[RD_LAT], bram_dout}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader: behavioural BRAM, scoreboard on
// the read stream, table-driven frames plus hand-written corner sequences.
module tb_bram_stream_loader;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              rd_start = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout = '0;
    logic              bram_en;
    logic              bram_we;
    logic              busy;
    logic [ADDR_W:0]   frame_len;
    logic              ovf;

    always #5 clk = ~clk;

    bram_stream_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .rd_start  (rd_start),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .busy      (busy),
        .frame_len (frame_len),
        .ovf       (ovf)
    );

    // Behavioural single-port BRAM with one cycle of read latency
    logic [DATA_W-1:0] bram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) bram[bram_addr] <= bram_din;
            else         bram_dout <= bram[bram_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    logic [DATA_W-1:0] fmodel [0:(1<<ADDR_W)-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: scoreboard pops, stall stability, read-issue ordering
    int first_seen = -1;
    int last_hs = -1;
    int hs_cnt = 0;
    int rd_issues = 0;
    int rd_addr_err = 0;
    int rd_exp_addr = 0;
    bit stalled = 1'b0;
    logic [DATA_W-1:0] held_d;
    logic held_l;

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (bram_en && !bram_we) begin
                rd_issues++;
                if (bram_addr != ADDR_W'(rd_exp_addr)) rd_addr_err++;
                rd_exp_addr++;
            end
            if (m_valid) begin
                if (first_seen < 0) first_seen = cyc;
                if (stalled) check("stall_hold", {23'd0, m_last, m_data}, {23'd0, held_l, held_d});
                if (m_ready) begin
                    check("sb_avail", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e.data);
                        check("m_last", m_last, e.last);
                    end
                    hs_cnt++;
                    last_hs = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d = m_data;
                    held_l = m_last;
                end
            end else begin
                if (stalled) check("stall_valid", m_valid, 1);
                stalled = 1'b0;
            end
        end
    end

    function automatic logic [DATA_W-1:0] gen(input int i, input logic [DATA_W-1:0] base);
        return (i == 0) ? base : DATA_W'(i * 17);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n beats starting at frame index start; checks the registered
    // BRAM write one cycle after each handshake and counts any deviation.
    task automatic write_beats(input int start, input int n, input bit last_on_end,
                               input logic [DATA_W-1:0] base, output int werr);
        werr = 0;
        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] d;
            int guard;
            d = gen(start + i, base);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = last_on_end && (i == n - 1);
            guard = 0;
            @(negedge clk);
            while (!s_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) werr++;
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (!(bram_en && bram_we && bram_addr == ADDR_W'(start + i) && bram_din == d)) werr++;
            fmodel[start + i] = d;
        end
    endtask

    task automatic prep_read(input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(beat_t'{fmodel[i], (i == len - 1)});
        first_seen  = -1;
        last_hs     = -1;
        hs_cnt      = 0;
        rd_exp_addr = 0;
        rd_addr_err = 0;
        rd_issues   = 0;
    endtask

    task automatic drain(input int len, input logic [3:0] pat, input int n0,
                         input int exp_lat, input string tag);
        int guard = 0;
        int k = 1;
        while ((busy || exp_q.size() != 0) && guard < 64 + 8 * len) begin
            m_ready = pat[k % 4];
            k++;
            tick();
            guard++;
        end
        m_ready = 1'b0;
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_lat"}, first_seen - n0, exp_lat);
        check({tag, "_rd_addr"}, rd_addr_err, 0);
        check({tag, "_rd_issues"}, rd_issues, len);
        if (pat == 4'b1111) check({tag, "_rate"}, last_hs - first_seen, len - 1);
        exp_q.delete();
    endtask

    task automatic read_frame(input int len, input logic [3:0] pat, input string tag);
        int n0;
        prep_read(len);
        rd_start = 1'b1;
        m_ready  = pat[0];
        n0 = cyc;
        tick();
        rd_start = 1'b0;
        drain(len, pat, n0, RD_LAT + 2, tag);
    endtask

    typedef struct {
        int              len;
        logic [DATA_W-1:0] base;
        logic [3:0]      pat;
        int              exp_len;
    } vec_t;

    vec_t vecs[5];
    int werr;
    int berr;
    int n0;
    int guard;

    initial begin
        vecs[0] = '{4,  8'h02, 4'b1111, 4};
        vecs[1] = '{4,  8'h02, 4'b1001, 4};
        vecs[2] = '{1,  8'hA5, 4'b1111, 1};
        vecs[3] = '{7,  8'h5C, 4'b0101, 7};
        vecs[4] = '{20, 8'h3E, 4'b1011, 20};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_addr", bram_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("idle_s_ready", s_ready, 1);
        check("idle_frame_len", frame_len, 0);
        check("idle_ovf", ovf, 0);

        // rd_start with nothing stored is ignored
        rd_issues = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("empty_rd_busy", busy, 0);
        repeat (4) tick();
        check("empty_rd_issues", rd_issues, 0);
        check("empty_rd_m_valid", m_valid, 0);

        // Table-driven frames: write, verify BRAM and length, replay
        for (int v = 0; v < 5; v++) begin
            write_beats(0, vecs[v].len, 1'b1, vecs[v].base, werr);
            check($sformatf("v%0d_wr_port", v), werr, 0);
            check($sformatf("v%0d_frame_len", v), frame_len, vecs[v].exp_len);
            check($sformatf("v%0d_busy", v), busy, 0);
            check($sformatf("v%0d_ovf", v), ovf, 0);
            berr = 0;
            tick();
            for (int i = 0; i < vecs[v].len; i++) if (bram[i] !== fmodel[i]) berr++;
            check($sformatf("v%0d_bram", v), berr, 0);
            read_frame(vecs[v].len, vecs[v].pat, $sformatf("v%0d", v));
        end

        // rd_start while a frame is being written is ignored
        write_beats(0, 2, 1'b0, 8'h70, werr);
        check("wrx_wr_port_a", werr, 0);
        check("wrx_busy_pre", busy, 1);
        rd_issues = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("wrx_busy", busy, 1);
        check("wrx_s_ready", s_ready, 1);
        tick();
        check("wrx_rd_issues", rd_issues, 0);
        write_beats(2, 1, 1'b1, 8'h70, werr);
        check("wrx_wr_port_b", werr, 0);
        check("wrx_frame_len", frame_len, 3);
        tick();
        read_frame(3, 4'b1111, "wrx");

        // rd_start and s_valid together in IDLE: beat lands at addr 0 first
        fmodel[0] = 8'hEE;
        prep_read(3);
        m_ready  = 1'b1;
        rd_start = 1'b1;
        s_valid  = 1'b1;
        s_data   = 8'hEE;
        s_last   = 1'b0;
        n0 = cyc;
        tick();
        rd_start = 1'b0;
        s_valid  = 1'b0;
        check("cc_write", {9'd0, bram_en, bram_we, bram_addr, bram_din},
                          {9'd0, 1'b1, 1'b1, 13'd0, 8'hEE});
        check("cc_s_ready", s_ready, 0);
        check("cc_busy", busy, 1);
        drain(3, 4'b1111, n0, RD_LAT + 3, "cc");

        // Overflow: 8192 beats without s_last, then a one-beat frame
        write_beats(0, 1 << ADDR_W, 1'b0, 8'h5A, werr);
        check("ovf_wr_port", werr, 0);
        check("ovf_frame_len", frame_len, 1 << ADDR_W);
        check("ovf_flag", ovf, 1);
        check("ovf_busy", busy, 0);
        write_beats(0, 1, 1'b1, 8'hC3, werr);
        check("ovf_next_wr_port", werr, 0);
        check("ovf_next_frame_len", frame_len, 1);
        check("ovf_sticky", ovf, 1);
        tick();
        read_frame(1, 4'b1111, "ovf_rd");

        // Reset in the middle of a replay after two beats
        write_beats(0, 6, 1'b1, 8'h90, werr);
        check("rmr_wr_port", werr, 0);
        tick();
        prep_read(6);
        rd_start = 1'b1;
        m_ready  = 1'b1;
        tick();
        rd_start = 1'b0;
        guard = 0;
        while (hs_cnt < 2 && guard < 40) begin
            tick();
            guard++;
        end
        check("rmr_two_beats", hs_cnt, 2);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("rmr_m_valid", m_valid, 0);
        check("rmr_busy", busy, 0);
        check("rmr_frame_len", frame_len, 0);
        check("rmr_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();
        rd_issues = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("rmr_rd_ignored_busy", busy, 0);
        repeat (6) tick();
        check("rmr_rd_issues", rd_issues, 0);
        check("rmr_m_valid_after", m_valid, 0);
        m_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
